// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: receiver, transmitter and ALU signal bundle for the command sequencer
interface alu_cmd_sequencer_if #(
  parameter int DATA_BITS = 8,
  parameter int OP_BITS = 6
);
  logic i_rx_done;
  logic [DATA_BITS-1:0] i_rx_data;
  logic [DATA_BITS-1:0] i_alu_result;
  logic i_tx_done;
  logic [DATA_BITS-1:0] o_dato_A;
  logic [DATA_BITS-1:0] o_dato_B;
  logic [OP_BITS-1:0] o_op;
  logic o_tx_start;
  logic [DATA_BITS-1:0] o_tx_data;
  logic o_busy;
  logic o_timeout;
  logic o_op_err;
  modport master (
    output i_rx_done, i_rx_data, i_alu_result, i_tx_done,
    input o_dato_A, o_dato_B, o_op, o_tx_start, o_tx_data, o_busy, o_timeout, o_op_err
  );
  modport slave (
    input i_rx_done, i_rx_data, i_alu_result, i_tx_done,
    output o_dato_A, o_dato_B, o_op, o_tx_start, o_tx_data, o_busy, o_timeout, o_op_err
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: assembles A/B/OP frames from the UART receiver, runs the ALU and transmits its result
module alu_cmd_sequencer #(
  parameter int DATA_BITS = 8,
  parameter int OP_BITS = 6,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter logic [DATA_BITS-1:0] ERR_CODE = DATA_BITS'(8'hEE)
) (
  input logic i_clk,
  input logic i_reset,
  alu_cmd_sequencer_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {GET_A, GET_B, GET_OP, EXEC, SEND, WAIT_TX} state_t;
  state_t state, state_nxt;
  logic [TW-1:0] timer;
  logic [OP_BITS-1:0] rx_op;
  logic op_ok, rx_op_ok, waiting, expire;
  assign rx_op = bus.i_rx_data[OP_BITS-1:0];
  assign rx_op_ok = (bus.i_rx_data >> OP_BITS) == '0 && rx_op inside {
    OP_BITS'(6'b100000), OP_BITS'(6'b100010), OP_BITS'(6'b100100), OP_BITS'(6'b100101),
    OP_BITS'(6'b100110), OP_BITS'(6'b100111), OP_BITS'(6'b000011), OP_BITS'(6'b000010)};
  assign waiting = state == GET_B || state == GET_OP;
  assign expire = waiting && !bus.i_rx_done && timer == TW'(TIMEOUT_CYCLES - 1);
  assign bus.o_busy = state inside {EXEC, SEND, WAIT_TX};
  assign bus.o_tx_start = state == SEND;
  always_ff @(posedge i_clk) state <= !i_reset ? GET_A : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      GET_A: state_nxt = bus.i_rx_done ? GET_B : GET_A;
      GET_B: state_nxt = bus.i_rx_done ? GET_OP : expire ? GET_A : GET_B;
      GET_OP: state_nxt = bus.i_rx_done ? EXEC : expire ? GET_A : GET_OP;
      EXEC: state_nxt = SEND;
      SEND: state_nxt = WAIT_TX;
      WAIT_TX: state_nxt = bus.i_tx_done ? GET_A : WAIT_TX;
      default: state_nxt = GET_A;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      timer <= '0;
      op_ok <= 1'b0;
      bus.o_dato_A <= '0;
      bus.o_dato_B <= '0;
      bus.o_op <= '0;
      bus.o_tx_data <= '0;
      bus.o_timeout <= 1'b0;
      bus.o_op_err <= 1'b0;
    end else begin
      timer <= waiting && !bus.i_rx_done && !expire ? timer + 1'b1 : '0;
      bus.o_timeout <= expire;
      bus.o_op_err <= state == EXEC && !op_ok;
      if (state == GET_A && bus.i_rx_done) bus.o_dato_A <= bus.i_rx_data;
      if (state == GET_B && bus.i_rx_done) bus.o_dato_B <= bus.i_rx_data;
      if (state == GET_OP && bus.i_rx_done) begin
        bus.o_op <= rx_op;
        op_ok <= rx_op_ok;
      end
      if (state == EXEC) bus.o_tx_data <= op_ok ? bus.i_alu_result : ERR_CODE;
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: randomized scoreboard bench for the ALU command sequencer
module tb_alu_cmd_sequencer;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] d;
    logic err;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic i_reset = 1'b0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int cur = 0;
  exp_t exp_q[$];
  int to_q[$];
  logic in_tx = 1'b0;
  logic [7:0] held = '0;
  logic [7:0] valid_ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
  alu_cmd_sequencer_if #(.DATA_BITS(8), .OP_BITS(6)) bus ();
  alu_cmd_sequencer #(.DATA_BITS(8), .OP_BITS(6), .TIMEOUT_CYCLES(100), .ERR_CODE(8'hEE)) dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] alu_ref(logic [7:0] a, logic [7:0] b, logic [5:0] op);
    logic signed [7:0] sa = a;
    case (op)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h03: return 8'(sa >>> b);
      6'h02: return a >> b;
      default: return 8'h00;
    endcase
  endfunction
  always_comb bus.i_alu_result = alu_ref(bus.o_dato_A, bus.o_dato_B, bus.o_op);
  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!i_reset) in_tx <= 1'b0;
    else begin
      if (bus.o_tx_start) begin
        if (exp_q.size() == 0) check("unexpected_tx_start", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("tx_latency_cycle", cyc, e.cyc);
          check("tx_data", {24'h0, bus.o_tx_data}, {24'h0, e.d});
          check("op_err", {31'h0, bus.o_op_err}, {31'h0, e.err});
          check("dato_A", {24'h0, bus.o_dato_A}, {24'h0, e.a});
          check("dato_B", {24'h0, bus.o_dato_B}, {24'h0, e.b});
          check("op", {26'h0, bus.o_op}, {26'h0, e.op});
          check("busy_at_start", {31'h0, bus.o_busy}, 1);
          held <= bus.o_tx_data;
          in_tx <= 1'b1;
        end
      end else if (bus.o_op_err) check("stray_op_err", 1, 0);
      if (bus.o_timeout) begin
        if (to_q.size() == 0) check("unexpected_timeout", 1, 0);
        else check("timeout_cycle", cyc, to_q.pop_front());
      end
      if (bus.i_tx_done && in_tx) begin
        check("tx_data_held", {24'h0, bus.o_tx_data}, {24'h0, held});
        check("busy_until_tx_done", {31'h0, bus.o_busy}, 1);
        in_tx <= 1'b0;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_byte(logic [7:0] d, int gap);
    repeat (gap) tick();
    bus.i_rx_done = 1'b1;
    bus.i_rx_data = d;
    cur = cyc;
    tick();
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = $urandom_range(0, 255);
  endtask
  task automatic wait_tx_start();
    bit seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = bus.o_tx_start;
    end
    if (!seen) check("tx_start_seen", 0, 1);
    tick();
  endtask
  task automatic frame_bytes(logic [7:0] a, logic [7:0] b, logic [7:0] op, int gb);
    exp_t e;
    bit ok = 0;
    foreach (valid_ops[i]) if (valid_ops[i] == op) ok = 1;
    send_byte(a, $urandom_range(0, 6));
    send_byte(b, gb);
    send_byte(op, $urandom_range(0, 6));
    e.a = a;
    e.b = b;
    e.op = op[5:0];
    e.err = !ok;
    e.d = ok ? alu_ref(a, b, op[5:0]) : 8'hEE;
    e.cyc = cur + 2;
    exp_q.push_back(e);
    wait_tx_start();
  endtask
  task automatic run_frame(logic [7:0] a, logic [7:0] b, logic [7:0] op, int gb, bit stray);
    frame_bytes(a, b, op, gb);
    repeat ($urandom_range(0, 3)) tick();
    if (stray) send_byte(8'hAA, 0);
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
    @(negedge clk);
    check("busy_after_tx_done", {31'h0, bus.o_busy}, 0);
    tick();
  endtask
  task automatic check_idle(string tag);
    @(negedge clk);
    check({tag, "_dato_A"}, {24'h0, bus.o_dato_A}, 0);
    check({tag, "_dato_B"}, {24'h0, bus.o_dato_B}, 0);
    check({tag, "_op"}, {26'h0, bus.o_op}, 0);
    check({tag, "_tx_data"}, {24'h0, bus.o_tx_data}, 0);
    check({tag, "_tx_start"}, {31'h0, bus.o_tx_start}, 0);
    check({tag, "_busy"}, {31'h0, bus.o_busy}, 0);
    check({tag, "_timeout"}, {31'h0, bus.o_timeout}, 0);
    check({tag, "_op_err"}, {31'h0, bus.o_op_err}, 0);
    tick();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
  initial begin
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = '0;
    bus.i_tx_done = 1'b0;
    i_reset = 1'b0;
    repeat (3) tick();
    check_idle("reset");
    i_reset = 1'b1;
    tick();
    run_frame(8'h05, 8'h03, 8'h20, 2, 0);
    run_frame(8'h0F, 8'h01, 8'h3F, 1, 0);
    send_byte(8'h11, 2);
    to_q.push_back(cur + 101);
    repeat (100) tick();
    run_frame(8'h07, 8'h02, 8'h22, 0, 0);
    run_frame(8'h33, 8'h44, 8'h26, 3, 1);
    run_frame(8'h01, 8'h01, 8'h20, 0, 0);
    run_frame(8'h90, 8'h0C, 8'h24, 99, 0);
    run_frame(8'h81, 8'h03, 8'h60, 4, 0);
    frame_bytes(8'h12, 8'h34, 8'h20, 2);
    repeat (2) tick();
    i_reset = 1'b0;
    tick();
    i_reset = 1'b1;
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
    check_idle("post_reset");
    repeat (4) tick();
    check_idle("post_reset_quiet");
    for (int n = 0; n < 30; n++) begin
      logic [7:0] op;
      op = $urandom_range(0, 5) == 0 ? 8'($urandom_range(0, 255)) : valid_ops[$urandom_range(0, 7)];
      run_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), op,
                $urandom_range(0, 8), 1'($urandom_range(0, 1)));
    end
    repeat (10) tick();
    check("exp_q_drained", exp_q.size(), 0);
    check("timeout_q_drained", to_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
